// File: rtl/inst_axi_responder_pkg.sv
// Shared constants and state type for the instruction-side AXI read responder.
// Also used by the kseg address translation helper.
package inst_axi_responder_pkg;

    typedef enum logic [1:0] {
        IR_IDLE = 2'd0,
        IR_ADDR = 2'd1,
        IR_DATA = 2'd2,
        IR_RESP = 2'd3
    } ir_state_e;

    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [31:0] KSEG_MASK      = 32'h1FFFFFFF;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/inst_axi_responder_vaddr_to_paddr.sv
// Combinational kseg0/kseg1 virtual-to-physical translation.
// Shared by the instruction-side and data-side responders.
module vaddr_to_paddr
    import inst_axi_responder_pkg::*;
#(
    parameter int KSEG_XLATE = 1
) (
    input  logic [31:0] vaddr_i,
    output logic [31:0] paddr_o
);

    assign paddr_o = (KSEG_XLATE != 0) ? (vaddr_i & KSEG_MASK) : vaddr_i;

endmodule

// File: rtl/inst_axi_responder.sv
// Instruction fetch responder: turns sram-like fetch requests into single-beat AXI4 reads,
// one outstanding at a time, with flush cancellation and a held response word.
module inst_axi_responder
    import inst_axi_responder_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         KSEG_XLATE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        fetch_ready,
    input  logic        flush,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    ir_state_e   state_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        cancel_q;
    logic [31:0] araddr_q;
    logic [31:0] rdata_q;
    logic [31:0] paddr_d;

    // Read id and response code carry no information for a single in-order master.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp};

    vaddr_to_paddr #(
        .KSEG_XLATE (KSEG_XLATE)
    ) u_xlate (
        .vaddr_i (inst_addr),
        .paddr_o (paddr_d)
    );

    // cancel_q remembers a flush seen while the read is in flight so the late word is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IR_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            cancel_q  <= 1'b0;
            araddr_q  <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            case (state_q)
                IR_IDLE: begin
                    if (inst_req && word_aligned(inst_addr[1:0])) begin
                        araddr_q  <= paddr_d;
                        arvalid_q <= 1'b1;
                        state_q   <= IR_ADDR;
                    end
                end
                IR_ADDR: begin
                    if (flush) begin
                        cancel_q <= 1'b1;
                    end
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= IR_DATA;
                    end
                end
                IR_DATA: begin
                    if (rvalid && rlast) begin
                        rready_q <= 1'b0;
                        cancel_q <= 1'b0;
                        if (cancel_q || flush) begin
                            state_q <= IR_IDLE;
                        end else begin
                            rdata_q <= rdata;
                            state_q <= IR_RESP;
                        end
                    end else if (flush) begin
                        cancel_q <= 1'b1;
                    end
                end
                IR_RESP: begin
                    if (flush || fetch_ready) begin
                        state_q <= IR_IDLE;
                    end
                end
                default: state_q <= IR_IDLE;
            endcase
        end
    end

    assign inst_addr_ok = (state_q == IR_IDLE);
    assign inst_data_ok = (state_q == IR_RESP) && fetch_ready && !flush;
    assign inst_rdata   = rdata_q;

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule

// File: tb/tb_inst_axi_responder.sv
// Scoreboard bench for inst_axi_responder: random AXI slave, transaction-level fetch model,
// and a monitor that checks every AR handshake and every returned word.
module tb_inst_axi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fetch_ready;
    logic        flush;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;

    logic [31:0] expQ[$];
    logic [31:0] arQ[$];

    int arReadyPct = 100;
    int rValidPct  = 100;
    int arHold     = 0;

    bit mBusy   = 1'b0;
    bit mHave   = 1'b0;
    bit mKilled = 1'b0;

    always #5 clk = ~clk;

    inst_axi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arlock       (arlock),
        .arcache      (arcache),
        .arprot       (arprot),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    // kseg0/kseg1 map onto the low 512 MB by dropping the top three address bits.
    function automatic logic [31:0] xlate(input logic [31:0] v);
        return {3'b000, v[28:0]};
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] pa);
        if (pa == 32'h1FC00000) return 32'h3C080001;
        return (pa * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock of stimulus followed by one step of the fetch-level model.
    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic fr,
                                 input logic fl, output logic dok);
        @(posedge clk);
        #1;
        inst_req    = req;
        inst_addr   = addr;
        fetch_ready = fr;
        flush       = fl;
        @(negedge clk);
        dok = inst_data_ok;
        checkOutput("addr_ok", {31'd0, inst_addr_ok}, {31'd0, !mBusy});
        if (!mBusy) begin
            if (req && addr[1:0] == 2'b00) begin
                mBusy   = 1'b1;
                mHave   = 1'b0;
                mKilled = 1'b0;
                expQ.push_back(memWord(xlate(addr)));
                arQ.push_back(xlate(addr));
            end
        end else if (!mHave) begin
            if (fl && !mKilled) begin
                mKilled = 1'b1;
                if (expQ.size() > 0) expQ.delete(expQ.size() - 1);
            end
            if (rvalid && rlast && rready) begin
                if (mKilled) mBusy = 1'b0;
                else         mHave = 1'b1;
            end
        end else begin
            if (fl) begin
                if (expQ.size() > 0) expQ.delete(expQ.size() - 1);
                mBusy = 1'b0;
            end else if (fr) begin
                mBusy = 1'b0;
            end
        end
    endtask

    // AXI slave: samples handshakes at negedge, drives its outputs 2 units after posedge.
    initial begin
        logic        arvalidS;
        logic        rreadyS;
        logic [31:0] araddrS;
        logic [31:0] rAddr;
        bit          inR;
        inR = 1'b0;
        rAddr = 32'h0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rid = 4'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            arvalidS = arvalid;
            rreadyS  = rready;
            araddrS  = araddr;
            @(posedge clk);
            #2;
            if (reset) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; inR = 1'b0;
            end else begin
                if (!inR) begin
                    if (arvalidS && arready) begin
                        inR = 1'b1;
                        rAddr = araddrS;
                        arready = 1'b0;
                    end else if (arHold > 0) begin
                        arready = 1'b0;
                        if (arvalidS) arHold--;
                    end else begin
                        arready = ($urandom_range(0, 99) < arReadyPct);
                    end
                end else if (rreadyS && rvalid) begin
                    rvalid = 1'b0; rlast = 1'b0; inR = 1'b0;
                end
                if (inR && !rvalid && ($urandom_range(0, 99) < rValidPct)) begin
                    rvalid = 1'b1;
                    rlast  = 1'b1;
                    rdata  = memWord(rAddr);
                    rresp  = 2'($urandom);
                    rid    = 4'($urandom);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every AR handshake and every presented word.
    initial begin
        logic        pV;
        logic        pR;
        logic [31:0] pA;
        pV = 1'b0; pR = 1'b0; pA = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pV = 1'b0;
                continue;
            end
            if (pV && !pR) begin
                checkOutput("arvalid_held", {31'd0, arvalid}, 32'd1);
                checkOutput("araddr_stable", araddr, pA);
            end
            if (arvalid && arready) begin
                if (arQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_ar: got araddr %h, required no request", araddr);
                end else begin
                    checkOutput("araddr", araddr, arQ.pop_front());
                end
                checkOutput("ar_const", {6'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
                            {6'd0, 4'd0, 8'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
            end
            if (inst_data_ok) begin
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_data_ok: got rdata %h, required no word", inst_rdata);
                end else begin
                    checkOutput("inst_rdata", inst_rdata, expQ.pop_front());
                end
            end
            pV = arvalid; pR = arready; pA = araddr;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        dok;
        logic [31:0] lastWord;
        logic [31:0] w;
        logic [31:0] a;
        int          budget;

        reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; fetch_ready = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
        checkOutput("rst_rready", {31'd0, rready}, 32'd0);
        checkOutput("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        checkOutput("rst_rdata", inst_rdata, 32'h0);
        checkOutput("rst_araddr", araddr, 32'h0);
        checkOutput("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        reset = 1'b0;

        // Basic fetch: data_ok lands exactly three cycles after acceptance.
        applyStimulus(1'b1, 32'hBFC00000, 1'b1, 1'b0, dok);
        checkOutput("basic_c0_dok", {31'd0, dok}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("basic_c1_dok", {31'd0, dok}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("basic_c2_dok", {31'd0, dok}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("basic_c3_dok", {31'd0, dok}, 32'd1);
        checkOutput("basic_rdata", inst_rdata, 32'h3C080001);

        // Fetch stall: word held while fetch_ready is low.
        w = memWord(xlate(32'hBFC00010));
        applyStimulus(1'b1, 32'hBFC00010, 1'b0, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, dok);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, dok);
            checkOutput("stall_dok", {31'd0, dok}, 32'd0);
            checkOutput("stall_rdata", inst_rdata, w);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("stall_release_dok", {31'd0, dok}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("stall_after_dok", {31'd0, dok}, 32'd0);

        // Flush while the address phase is stalled.
        lastWord = inst_rdata;
        arHold = 3;
        applyStimulus(1'b1, 32'h9FC00100, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, dok);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
            checkOutput("flush_addr_dok", {31'd0, dok}, 32'd0);
        end
        checkOutput("flush_addr_rdata", inst_rdata, lastWord);
        applyStimulus(1'b1, 32'h80000200, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("after_flush_dok", {31'd0, dok}, 32'd1);

        // Flush coincident with the data beat.
        lastWord = inst_rdata;
        applyStimulus(1'b1, 32'hBFC00300, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, dok);
        checkOutput("flush_r_beat", {31'd0, rvalid & rready}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("flush_r_dok", {31'd0, dok}, 32'd0);
        checkOutput("flush_r_rdata", inst_rdata, lastWord);

        // Misaligned request is accepted but goes nowhere.
        applyStimulus(1'b1, 32'hBFC00002, 1'b1, 1'b0, dok);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
            checkOutput("misaligned_arvalid", {31'd0, arvalid}, 32'd0);
            checkOutput("misaligned_dok", {31'd0, dok}, 32'd0);
        end

        // Random traffic against the fetch-level model.
        arReadyPct = 60;
        rValidPct  = 60;
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            applyStimulus(($urandom_range(0, 2) != 0), a, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 11) == 0), dok);
        end
        budget = 0;
        while (mBusy && budget < 100) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
            budget++;
        end
        if (mBusy) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout: got busy after %0d cycles, required idle", budget);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("exp_queue_empty", expQ.size(), 32'd0);
        checkOutput("ar_queue_empty", arQ.size(), 32'd0);

        // Asynchronous reset in the middle of the data phase.
        arReadyPct = 100;
        rValidPct  = 0;
        applyStimulus(1'b1, 32'hBFC00400, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("pre_reset_rready", {31'd0, rready}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("areset_arvalid", {31'd0, arvalid}, 32'd0);
        checkOutput("areset_rready", {31'd0, rready}, 32'd0);
        checkOutput("areset_data_ok", {31'd0, inst_data_ok}, 32'd0);
        checkOutput("areset_rdata", inst_rdata, 32'h0);
        mBusy = 1'b0; mHave = 1'b0; mKilled = 1'b0;
        expQ.delete();
        arQ.delete();
        @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        rValidPct = 60;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, dok);
        checkOutput("post_reset_addr_ok", {31'd0, inst_addr_ok}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_axi_responder.md
Name: inst_axi_responder

Overview:
- Instruction-side responder for the fetch path.
- Accepts sram-like fetch requests (inst_req/inst_addr, acknowledged by inst_addr_ok) and returns words to the IF stage via inst_data_ok/inst_rdata.
- Converts each accepted request into a single-beat AXI4 read, with one outstanding transaction at a time.
- Handles pipeline flush by cancelling the in-flight word, and holds the returned word until the fetch side is ready.

Parameters:
- AXI_ID, 4'd0, value driven on arid.
- KSEG_XLATE, 1, when 1 the physical address is inst_addr & 32'h1FFFFFFF (kseg0/kseg1 unmapped); when 0 the address passes through unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- inst_req  in  1  fetch request valid.
- inst_addr  in  32  fetch virtual address (the pre-IF next pc).
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  inst_rdata valid this cycle; consumed this cycle.
- inst_rdata  out  32  returned instruction; holds its last value between responses.
- fetch_ready  in  1  IF stage can take a word (fs_allowin).
- flush  in  1  exception/eret redirect; discard the outstanding word.
- arid  out  4  read id.
- araddr  out  32  read address.
- arlen  out  8  read burst length.
- arsize  out  3  read transfer size.
- arburst  out  2  read burst type.
- arlock  out  2  lock.
- arcache  out  4  cache attributes.
- arprot  out  3  protection.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rid  in  4  read id (ignored).
- rdata  in  32  read data.
- rresp  in  2  read response (ignored).
- rlast  in  1  last beat.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.

Behaviour:
- Constant AXI outputs: arid=AXI_ID, arlen=0, arsize=3'b010, arburst=2'b01, arlock=0, arcache=0, arprot=0.
- Reset (async): state=IDLE, arvalid=0, rready=0, inst_data_ok=0, inst_rdata=0, cancel=0, araddr=0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - inst_addr_ok=1.
  - On inst_req with inst_addr[1:0]==0: latch the translated address into araddr and go to ADDR; arvalid=1 from the next cycle.
  - On inst_req with a misaligned address: accept (addr_ok=1), stay in IDLE, issue no AXI transaction and no data_ok. The IF stage raises AdEL itself.
- ADDR:
  - arvalid=1, araddr stable.
  - On arready: go to DATA and drop arvalid the next cycle.
  - arvalid is never retracted, including on flush.
- DATA:
  - rready=1.
  - On rvalid&rlast: if cancel=1 (or flush is high this cycle), clear cancel and go to IDLE with rdata discarded.
  - Otherwise capture rdata into inst_rdata and go to RESP.
- RESP:
  - inst_data_ok = fetch_ready & ~flush (combinational).
  - When data_ok=1, go to IDLE next cycle.
  - While fetch_ready=0, stay in RESP with inst_rdata held.
  - flush in RESP: go to IDLE and drop the word; data_ok=0 that cycle.
- inst_addr_ok is 0 in ADDR/DATA/RESP, so there is only ever one outstanding request.
- Latency with arready and rvalid each 1 in their first cycle: request accepted at cycle 0, arvalid at 1, rvalid at 2, inst_data_ok at 3.
- flush in ADDR or DATA sets cancel; that word is never presented.
- A flush in IDLE coincident with inst_req accepts the new (redirect) request normally.
- flush and rvalid&rlast in the same DATA cycle: the word is discarded.
- rresp errors are ignored: the data is returned as-is, with no bus-error exception.
- inst_rdata updates only on capture in DATA.

Decomposition:
- global_defines.vh: AXI constants (`AXI_SIZE_4B, `AXI_BURST_INCR), state encodings (`IR_IDLE..`IR_RESP, 2 bits), `KSEG_MASK 32'h1FFFFFFF.
- One optional combinational sub-module vaddr_to_paddr (kseg translation), to be shared with the data-side responder.
- The FSM stays in this module.

Test Plan:
- Basic fetch: inst_req=1, addr=32'hBFC00000; arready=1 and rvalid=1 (rdata=32'h3C080001) each in the first cycle offered -> araddr=32'h1FC00000, arlen=0, arsize=2, inst_data_ok at cycle 3 with inst_rdata=32'h3C080001.
- Fetch stall: fetch_ready=0 for 4 cycles after capture -> data_ok stays 0 and inst_rdata held; data_ok pulses exactly once in the cycle fetch_ready rises; addr_ok=1 the next cycle.
- Flush in ADDR: arready delayed 3 cycles, flush pulsed at cycle 1 -> arvalid stays high until arready; returned word discarded; no data_ok; next request served normally.
- Flush with rvalid: flush in the same cycle as rvalid&rlast -> no data_ok, inst_rdata unchanged, state IDLE.
- Misaligned: inst_addr=32'hBFC00002 -> addr_ok=1, arvalid never rises, no data_ok.
- Async reset mid-DATA: reset asserted between clock edges -> arvalid, rready, inst_data_ok immediately 0; inst_rdata=0; after release, addr_ok=1.
